i2c_master_ctrl: RTL

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

---
 rtl/i2c_pkg.sv | 6 +
 rtl/i2c_tick_gen.sv | 19 +
 rtl/i2c_master_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus acknowledge levels for the I2C master
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_e;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: one-cycle quarter-period tick every CLK_DIV clocks while enabled
module i2c_tick_gen #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = en && cnt_q == W'(CLK_DIV - 1);
  // counter sits at zero while disabled so every transaction starts on a fresh quarter
  always_comb cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master, one address phase plus one data byte
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sda_i,
  output logic              scl_oe,
  output logic              sda_oe,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err
);
  localparam int BW = $clog2(ADDR_W + 1 > DATA_W ? ADDR_W + 1 : DATA_W);
  state_e            state_q, state_d;
  logic [1:0]        qc_q, qc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [ADDR_W:0]   ash_q, ash_d;
  logic [DATA_W-1:0] dsh_q, dsh_d, rdata_q, rdata_d;
  logic              rw_q, rw_d, busy_q, busy_d, done_q, done_d, ack_q, ack_d;
  logic              scl_q, scl_d, sda_q, sda_d;
  logic              tick;
  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (.clk(clk), .rst(rst), .en(busy_q), .tick(tick));
  assign scl_oe  = scl_q;
  assign sda_oe  = sda_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_q;
  // sequencing: quarters within a slot, slots within a state; bus levels derived from next state
  always_comb begin
    state_d = state_q;
    qc_d    = qc_q;
    bit_d   = bit_q;
    ash_d   = ash_q;
    dsh_d   = dsh_q;
    rw_d    = rw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ack_d   = ack_q;
    rdata_d = rdata_q;
    if (!busy_q && start) begin
      state_d = START;
      qc_d    = '0;
      bit_d   = '0;
      ash_d   = {addr, rw};
      dsh_d   = wdata;
      rw_d    = rw;
      busy_d  = 1'b1;
      ack_d   = 1'b0;
    end else if (tick) begin
      qc_d = qc_q + 2'd1;
      if (qc_q == 2'd2) begin
        if (state_q == ADDR_ACK || (state_q == DATA_ACK && !rw_q)) ack_d = sda_i != ACK;
        if (state_q == DATA && rw_q) dsh_d = {dsh_q[DATA_W-2:0], sda_i};
      end
      if (qc_q == 2'd3) begin
        bit_d = bit_q + 1'b1;
        case (state_q)
          START: begin
            state_d = ADDR;
            bit_d   = '0;
          end
          ADDR: begin
            ash_d = ash_q << 1;
            if (bit_q == BW'(ADDR_W)) state_d = ADDR_ACK;
          end
          ADDR_ACK: begin
            state_d = ack_q ? STOP : DATA;
            bit_d   = '0;
          end
          DATA: begin
            if (!rw_q) dsh_d = dsh_q << 1;
            if (bit_q == BW'(DATA_W - 1)) state_d = DATA_ACK;
          end
          DATA_ACK: begin
            state_d = STOP;
            if (rw_q) rdata_d = dsh_q;
          end
          STOP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
    scl_d = 1'b0;
    sda_d = 1'b0;
    case (state_d)
      START: begin
        scl_d = qc_d == 2'd3;
        sda_d = qc_d != 2'd0;
      end
      ADDR: begin
        scl_d = !qc_d[1];
        sda_d = !ash_d[ADDR_W];
      end
      ADDR_ACK, DATA_ACK: begin
        scl_d = !qc_d[1];
        sda_d = !NACK;
      end
      DATA: begin
        scl_d = !qc_d[1];
        sda_d = !rw_d && !dsh_d[DATA_W-1];
      end
      STOP: begin
        scl_d = qc_d == 2'd0;
        sda_d = !qc_d[1];
      end
      default: ;
    endcase
  end
  // state and registered outputs; reset drops the bus without a STOP
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      qc_q    <= '0;
      bit_q   <= '0;
      ash_q   <= '0;
      dsh_q   <= '0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      scl_q   <= 1'b0;
      sda_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qc_q    <= qc_d;
      bit_q   <= bit_d;
      ash_q   <= ash_d;
      dsh_q   <= dsh_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
endmodule
